// File: rtl/addsub_arb_pkg.sv
// addsub_arb_pkg: shared constants for the add/subtract arbiter slice.
// Holds the FSM encodings, the opcode values and the bit positions of the
// response flags so the top, the datapath and the bench agree on them.
package addsub_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      EXEC = ST_EXEC,
      RESP = ST_RESP
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int FLAG_COUT  = 3;
   localparam int FLAG_OVERF = 2;
   localparam int FLAG_ZEROF = 1;
   localparam int FLAG_NEGF  = 0;

endpackage

// File: rtl/addsub_unit.sv
// addsub_unit: combinational WIDTH-bit add/subtract with flag generation.
// Subtraction is a + ~b + 1, so the carry out of the MSB is the inverse of
// the borrow. The carry into the MSB is recovered from the MSB sum bit,
// which gives the signed-overflow term without exposing every ripple stage.
module addsub_unit
   import addsub_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             carry_msb_in,
   output logic             carry_msb_out,
   output logic [3:0]       flags
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_full;
   logic             overf;

   // Carry chain, borrow conversion and the four status flags.
   always_comb begin
      b_eff         = (op == OP_SUB) ? ~b : b;
      sum_full      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op};
      result        = sum_full[WIDTH-1:0];
      carry_msb_out = sum_full[WIDTH];
      carry_msb_in  = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_full[WIDTH-1];
      cout          = (op == OP_SUB) ? ~carry_msb_out : carry_msb_out;
      overf         = carry_msb_out ^ carry_msb_in;
      flags             = 4'b0000;
      flags[FLAG_COUT]  = cout;
      flags[FLAG_OVERF] = overf;
      flags[FLAG_ZEROF] = (sum_full[WIDTH-1:0] == '0) && !overf;
      flags[FLAG_NEGF]  = sum_full[WIDTH-1];
   end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two-requester arbiter and sequencer for one shared
// add/subtract datapath. A command is accepted in IDLE, computed in EXEC
// and held in RESP until the owning requester takes the response.
// Build option: define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 always wins ties, no last-grant state); otherwise ties are
// resolved round-robin.
module addsub_arbiter
   import addsub_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [1:0]         req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic [3:0]         rsp_flags
);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             grant;
   logic             accept;
   logic             owner;
   logic             op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;

   logic [WIDTH-1:0] unit_result;
   logic             unit_cout;
   logic             unit_carry_in;
   logic             unit_carry_out;
   logic [3:0]       unit_flags;
   logic             unused_carries;

`ifndef ADDSUB_ARB_FIXED_PRIO_EN
   logic             last_grant;
`endif

   // Choose which requester would win if a command is taken this cycle.
   always_comb begin
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
      grant = ~req_valid[0];
`else
      if (req_valid == 2'b11) begin
         grant = ~last_grant;
      end else begin
         grant = req_valid[1];
      end
`endif
   end

   // Acceptance and the handshake outputs only ever address one requester.
   always_comb begin
      accept    = (state == ST_IDLE) && (req_valid != 2'b00);
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      if (accept) begin
         req_ready[grant] = 1'b1;
      end
      if (state == ST_RESP) begin
         rsp_valid[owner] = 1'b1;
      end
   end

   // Sequencer: one command at a time, non-owner rsp_ready is ignored.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept) state_next = ST_EXEC;
         ST_EXEC: state_next = ST_RESP;
         ST_RESP: if (rsp_ready[owner]) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State register; reset drops any command in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Latch the granted command so requesters are free once accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner  <= 1'b0;
         op_reg <= OP_ADD;
         a_reg  <= '0;
         b_reg  <= '0;
      end else if (accept) begin
         owner  <= grant;
         op_reg <= grant ? req_op[1] : req_op[0];
         a_reg  <= grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
         b_reg  <= grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
      end
   end

`ifndef ADDSUB_ARB_FIXED_PRIO_EN
   // Remember the last winner; starting at 1 lets requester 0 win first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= grant;
      end
   end
`endif

   addsub_unit #(
      .WIDTH(WIDTH)
   ) u_addsub (
      .op            (op_reg),
      .a             (a_reg),
      .b             (b_reg),
      .result        (unit_result),
      .cout          (unit_cout),
      .carry_msb_in  (unit_carry_in),
      .carry_msb_out (unit_carry_out),
      .flags         (unit_flags)
   );

   // The raw carries are already folded into the flags; this only sinks them.
   assign unused_carries = ^{unit_cout, unit_carry_in, unit_carry_out};

   // Capture the datapath output in EXEC; it then holds through RESP and after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result <= '0;
         rsp_flags  <= 4'b0000;
      end else if (state == ST_EXEC) begin
         rsp_result <= unit_result;
         rsp_flags  <= unit_flags;
      end
   end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-requester arbiter and sequencer for one shared 32-bit adder/subtractor datapath. It accepts add or subtract commands from two independent requesters over valid/ready handshakes and grants the datapath to one requester at a time. It registers operands, result and status flags (carry/borrow, overflow, zero, negative), then returns the response to the granted requester. It sits between the lab3 control logic and the arithmetic unit, so the adder and subtractor can be instantiated once.

## Interface
Parameters:
- WIDTH, 32: operand and result width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  2  per-requester command valid; bit i belongs to requester i.
- req_ready  out  2  per-requester command accepted this cycle.
- req_op  in  2  per-requester opcode: 0 = add, 1 = subtract (a - b).
- req_a  in  2*WIDTH  operands A; requester i is in [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operands B, same packing as req_a.
- rsp_valid  out  2  one-hot response valid, addressed to the owning requester.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  WIDTH  sum or difference.
- rsp_flags  out  4  {cout, overf, zerof, negf}.

## Operation
- States:
  - IDLE: accepts a new command.
  - EXEC: the shared datapath computes.
  - RESP: holds the response until it is accepted.
- IDLE:
  - If any req_valid is set, grant one requester, assert req_ready[g] combinationally and latch op, a, b and g.
  - Go to EXEC.
  - req_ready is 0 in every state other than IDLE.
- Arbitration: round-robin over the 2 requesters.
  - last_grant register; reset value = 1, so requester 0 wins the first tie.
  - On a tie, grant the requester that is not last_grant. A lone request is always granted.
  - last_grant updates only on a grant.
- EXEC: register the result and flags from the shared unit, then go to RESP.
- RESP:
  - rsp_valid[g] = 1.
  - On rsp_ready[g], go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Arithmetic: modulo 2^WIDTH.
  - Add: cout = carry out of the MSB.
  - Subtract: cout = borrow out, i.e. 1 when a < b unsigned.
  - overf = signed overflow, equal to carry(MSB) XOR carry(MSB-1) of the ripple chain.
  - zerof = (result == 0) AND NOT overf.
  - negf = result[MSB].
- Requester i must hold req_op/a/b stable while req_valid[i]=1 and req_ready[i]=0.
- Dropping req_valid before it is granted is allowed; nothing is issued for it.
- Reset mid-operation: the in-flight command is discarded and no response is produced. Requesters re-issue after reset.

## Timing
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, last_grant=1.
- Latency: accept edge T, result registered at T+1, rsp_valid high from T+1 until accepted.
- Minimum 3 cycles per command (IDLE, EXEC, RESP with immediate rsp_ready). Throughput is 1 command per 3 cycles.
- rsp_result and rsp_flags stay stable while rsp_valid is high. After acceptance they hold their last value.
- A request that arrives during EXEC or RESP waits. It is granted in the first IDLE cycle that follows.

## Configuration
- ADDSUB_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins ties, and last_grant is not implemented.
- ADDSUB_ARB_FIXED_PRIO_EN undefined (default): round-robin as described under Operation.

## Structure
- Package addsub_arb_pkg holds:
  - state enum (IDLE/EXEC/RESP);
  - opcode constants OP_ADD=0, OP_SUB=1;
  - flag bit indices FLAG_COUT=3, FLAG_OVERF=2, FLAG_ZEROF=1, FLAG_NEGF=0.
- One sub-module, addsub_unit: combinational WIDTH-bit ripple add/subtract with op select. It outputs result, cout/borrow, the carries into and out of the MSB, and the four flags. It is instantiated once.
- The arbiter FSM, operand registers and grant register stay in the top module.

## Test plan
- Reset: hold rst_n=0, then release. All outputs are 0. A single req_valid[0] add of 5+7 gives rsp_valid=2'b01, result=12, flags=4'b0000.
- Flags: 0x7FFFFFFF+1 gives result 0x80000000, flags {0,1,0,1}. 0xFFFFFFFF+1 gives result 0, flags {1,0,1,0}. Subtract 3-5 gives 0xFFFFFFFE, flags {1,0,0,1}.
- Round-robin: both requesters hold valid for 4 commands. Grants go 0,1,0,1, with each response one-hot to its owner. With the macro defined, the same stimulus grants 0,0,0,0.
- Response backpressure: hold rsp_ready low for 5 cycles. rsp_valid and result stay stable, and req_ready stays 0 for both requesters.
- Reset mid-operation: assert rst_n=0 during EXEC. rsp_valid never asserts for that command, and the next command completes normally.
- Retracted request: req_valid[1] pulses for one cycle while the block is in RESP. No grant or response is ever produced for requester 1.
